mips_multicycle_controller: RTL and testbench

//  Control FSM for the multi-cycle MIPS datapath; the sequential successor to the single-cycle main decoder.

---
 rtl/mips_multicycle_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller
//   Control FSM for the multi-cycle MIPS datapath. Steps each instruction
//   through fetch / decode / execute / memory / writeback states. It stalls
//   in the memory states until mem_ready. An optional watchdog aborts a
//   memory state that waits too long.
//
// Parameters
//   EXT_EN      : 1 adds bne / andi / ori to the decode; 0 makes them illegal
//   MEM_WAIT_EN : 1 memory states wait for mem_ready; 0 mem_ready treated as 1
//   TIMEOUT     : 0 no watchdog; N>0 abort a memory state after N stalled cycles
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   op_code[5:0]          : IR[31:26]
//   mem_ready             : memory handshake for FETCH / MEMRD / MEMWR
//   mem_req, iord, mem_w  : memory request, address select, write strobe
//   ir_w, pc_w            : IR load / unconditional PC write
//   branch, branch_ne     : conditional PC write on zero / not zero
//   pc_src, alu_src_a/b   : datapath mux selects
//   alu_op, imm_zext      : ALU decoder control, immediate zero-extend
//   reg_dest, mem_to_reg  : register file write port selects
//   reg_w                 : register file write enable
//   illegal_op            : 1-cycle pulse on an unknown opcode in DECODE
//   mem_timeout           : sticky watchdog flag, cleared only by reset
//   state[3:0]            : current state encoding (debug)
module mips_multicycle_controller #(
    parameter bit          EXT_EN      = 1'b1,
    parameter bit          MEM_WAIT_EN = 1'b1,
    parameter int unsigned TIMEOUT     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_w,
    output logic       ir_w,
    output logic       pc_w,
    output logic       branch,
    output logic       branch_ne,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       imm_zext,
    output logic       reg_dest,
    output logic       mem_to_reg,
    output logic       reg_w,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);
    localparam bit            WD_ON    = (TIMEOUT > 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    // Opcode decode; the extended opcodes vanish when EXT_EN=0
    logic op_lw, op_sw, op_r, op_beq, op_bne, op_addi, op_andi, op_ori, op_j, op_logic;
    always_comb begin
        op_lw    = (op_code == 6'b100011);
        op_sw    = (op_code == 6'b101011);
        op_r     = (op_code == 6'b000000);
        op_beq   = (op_code == 6'b000100);
        op_bne   = EXT_EN && (op_code == 6'b000101);
        op_addi  = (op_code == 6'b001000);
        op_andi  = EXT_EN && (op_code == 6'b001100);
        op_ori   = EXT_EN && (op_code == 6'b001101);
        op_j     = (op_code == 6'b000010);
        op_logic = op_andi || op_ori;
    end

    logic rdy, mem_state, expire;

    always_comb begin
        rdy       = MEM_WAIT_EN ? mem_ready : 1'b1;
        mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        // mem_ready on the expiry cycle takes priority over the watchdog
        expire    = WD_ON && mem_state && !rdy && ((cnt_q + CW'(1)) == TO_LIMIT);
        // Counter only runs while stalled in a memory state, so any state change clears it
        cnt_d     = (WD_ON && mem_state && !rdy && !expire) ? cnt_q + CW'(1) : '0;
        tmo_d     = tmo_q || expire;

        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = expire ? S_FETCH : (rdy ? S_DECODE : S_FETCH);
            S_DECODE: begin
                if (op_lw || op_sw)           state_d = S_MEMADR;
                else if (op_r)                state_d = S_EXEC;
                else if (op_beq || op_bne)    state_d = S_BRANCH;
                else if (op_addi || op_logic) state_d = S_IMMEX;
                else if (op_j)                state_d = S_JUMP;
                else                          state_d = S_FETCH;
            end
            S_MEMADR: state_d = op_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = expire ? S_FETCH : (rdy ? S_MEMWB : S_MEMRD);
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = (expire || rdy) ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IMMEX:  state_d = S_IMMWB;
            S_IMMWB:  state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Output decode of the state register. rst_n gates everything so nothing
    // is requested while reset is held.
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        pc_w       = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        imm_zext   = 1'b0;
        reg_dest   = 1'b0;
        mem_to_reg = 1'b0;
        reg_w      = 1'b0;
        illegal_op = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    ir_w      = rdy;
                    pc_w      = rdy;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = !(op_lw || op_sw || op_r || op_beq || op_bne ||
                                   op_addi || op_logic || op_j);
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    reg_w      = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_w   = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_w    = 1'b1;
                    reg_dest = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    branch    = op_beq;
                    branch_ne = op_bne;
                end
                S_IMMEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = op_logic ? 2'b11 : 2'b00;
                    imm_zext  = op_logic;
                end
                S_IMMWB: begin
                    reg_w    = 1'b1;
                    imm_zext = op_logic;
                end
                S_JUMP: begin
                    pc_src = 2'b10;
                    pc_w   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state       = state_q;
    assign mem_timeout = tmo_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
module tb_mips_multicycle_controller;

    // Packed output word: {mem_req,iord,mem_w,ir_w,pc_w,branch,branch_ne,pc_src,
    //  alu_src_a,alu_src_b,alu_op,imm_zext,reg_dest,mem_to_reg,reg_w,illegal_op,
    //  mem_timeout,state}
    localparam logic [23:0] MREQ  = 24'h800000;
    localparam logic [23:0] IORD  = 24'h400000;
    localparam logic [23:0] MEMW  = 24'h200000;
    localparam logic [23:0] IRW   = 24'h100000;
    localparam logic [23:0] PCW   = 24'h080000;
    localparam logic [23:0] BR    = 24'h040000;
    localparam logic [23:0] BRNE  = 24'h020000;
    localparam logic [23:0] PCS10 = 24'h010000;
    localparam logic [23:0] PCS01 = 24'h008000;
    localparam logic [23:0] ASA   = 24'h004000;
    localparam logic [23:0] ASB11 = 24'h003000;
    localparam logic [23:0] ASB10 = 24'h002000;
    localparam logic [23:0] ASB01 = 24'h001000;
    localparam logic [23:0] AOP11 = 24'h000C00;
    localparam logic [23:0] AOP10 = 24'h000800;
    localparam logic [23:0] AOP01 = 24'h000400;
    localparam logic [23:0] ZEXT  = 24'h000200;
    localparam logic [23:0] RDST  = 24'h000100;
    localparam logic [23:0] M2R   = 24'h000080;
    localparam logic [23:0] REGW  = 24'h000040;
    localparam logic [23:0] ILL   = 24'h000020;
    localparam logic [23:0] TMO   = 24'h000010;
    localparam logic [23:0] FETCH_OK = MREQ | ASB01 | IRW | PCW;
    localparam logic [23:0] FETCH_ST = MREQ | ASB01;

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_J = 6'b000010,
                           OP_BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [23:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic [2:0] rst_v = 3'b000;
    logic [2:0] rdy_v = 3'b000;
    logic [5:0] op_v [3];

    logic [2:0] w_mem_req, w_iord, w_mem_w, w_ir_w, w_pc_w, w_branch, w_branch_ne;
    logic [2:0] w_alu_src_a, w_imm_zext, w_reg_dest, w_mem_to_reg, w_reg_w;
    logic [2:0] w_illegal_op, w_mem_timeout;
    logic [1:0] w_pc_src [3];
    logic [1:0] w_alu_src_b [3];
    logic [1:0] w_alu_op [3];
    logic [3:0] w_state [3];
    logic [23:0] obus [3];

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    // 0: defaults (EXT_EN=1, waits, no watchdog)
    mips_multicycle_controller dut_m (
        .clk(clk), .rst_n(rst_v[0]), .op_code(op_v[0]), .mem_ready(rdy_v[0]),
        .mem_req(w_mem_req[0]), .iord(w_iord[0]), .mem_w(w_mem_w[0]), .ir_w(w_ir_w[0]),
        .pc_w(w_pc_w[0]), .branch(w_branch[0]), .branch_ne(w_branch_ne[0]),
        .pc_src(w_pc_src[0]), .alu_src_a(w_alu_src_a[0]), .alu_src_b(w_alu_src_b[0]),
        .alu_op(w_alu_op[0]), .imm_zext(w_imm_zext[0]), .reg_dest(w_reg_dest[0]),
        .mem_to_reg(w_mem_to_reg[0]), .reg_w(w_reg_w[0]), .illegal_op(w_illegal_op[0]),
        .mem_timeout(w_mem_timeout[0]), .state(w_state[0]));

    // 1: base ISA only, memory handshake ignored
    mips_multicycle_controller #(.EXT_EN(1'b0), .MEM_WAIT_EN(1'b0), .TIMEOUT(0)) dut_x (
        .clk(clk), .rst_n(rst_v[1]), .op_code(op_v[1]), .mem_ready(rdy_v[1]),
        .mem_req(w_mem_req[1]), .iord(w_iord[1]), .mem_w(w_mem_w[1]), .ir_w(w_ir_w[1]),
        .pc_w(w_pc_w[1]), .branch(w_branch[1]), .branch_ne(w_branch_ne[1]),
        .pc_src(w_pc_src[1]), .alu_src_a(w_alu_src_a[1]), .alu_src_b(w_alu_src_b[1]),
        .alu_op(w_alu_op[1]), .imm_zext(w_imm_zext[1]), .reg_dest(w_reg_dest[1]),
        .mem_to_reg(w_mem_to_reg[1]), .reg_w(w_reg_w[1]), .illegal_op(w_illegal_op[1]),
        .mem_timeout(w_mem_timeout[1]), .state(w_state[1]));

    // 2: watchdog of 8 cycles
    mips_multicycle_controller #(.EXT_EN(1'b1), .MEM_WAIT_EN(1'b1), .TIMEOUT(8)) dut_t (
        .clk(clk), .rst_n(rst_v[2]), .op_code(op_v[2]), .mem_ready(rdy_v[2]),
        .mem_req(w_mem_req[2]), .iord(w_iord[2]), .mem_w(w_mem_w[2]), .ir_w(w_ir_w[2]),
        .pc_w(w_pc_w[2]), .branch(w_branch[2]), .branch_ne(w_branch_ne[2]),
        .pc_src(w_pc_src[2]), .alu_src_a(w_alu_src_a[2]), .alu_src_b(w_alu_src_b[2]),
        .alu_op(w_alu_op[2]), .imm_zext(w_imm_zext[2]), .reg_dest(w_reg_dest[2]),
        .mem_to_reg(w_mem_to_reg[2]), .reg_w(w_reg_w[2]), .illegal_op(w_illegal_op[2]),
        .mem_timeout(w_mem_timeout[2]), .state(w_state[2]));

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            obus[i] = {w_mem_req[i], w_iord[i], w_mem_w[i], w_ir_w[i], w_pc_w[i],
                       w_branch[i], w_branch_ne[i], w_pc_src[i], w_alu_src_a[i],
                       w_alu_src_b[i], w_alu_op[i], w_imm_zext[i], w_reg_dest[i],
                       w_mem_to_reg[i], w_reg_w[i], w_illegal_op[i], w_mem_timeout[i],
                       w_state[i]};
        end
    end

    task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %06h expected %06h", nm, got, exp);
        end
    endtask

    // Called at a falling edge: drive, settle, compare, then advance one clock
    task automatic step(input int sel, input logic [5:0] op, input logic rdy,
                        input logic [23:0] exp, input string nm);
        op_v[sel]  = op;
        rdy_v[sel] = rdy;
        #1;
        chk(nm, obus[sel], exp);
        @(negedge clk);
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input logic [23:0] exp);
        vec_t v;
        v.op = op; v.rdy = rdy; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) op_v[i] = 6'b000000;

        // lw, no waits: 0,1,2,3,4
        add(OP_LW, 1'b1, FETCH_OK | 24'd0);
        add(OP_LW, 1'b1, ASB11 | 24'd1);
        add(OP_LW, 1'b1, ASA | ASB10 | 24'd2);
        add(OP_LW, 1'b1, MREQ | IORD | 24'd3);
        add(OP_LW, 1'b1, REGW | M2R | 24'd4);
        // sw, MEMWR stalled 3 cycles
        add(OP_SW, 1'b1, FETCH_OK | 24'd0);
        add(OP_SW, 1'b1, ASB11 | 24'd1);
        add(OP_SW, 1'b1, ASA | ASB10 | 24'd2);
        add(OP_SW, 1'b0, MREQ | IORD | MEMW | 24'd5);
        add(OP_SW, 1'b0, MREQ | IORD | MEMW | 24'd5);
        add(OP_SW, 1'b0, MREQ | IORD | MEMW | 24'd5);
        add(OP_SW, 1'b1, MREQ | IORD | MEMW | 24'd5);
        // R-type with one fetch wait state
        add(OP_R, 1'b0, FETCH_ST | 24'd0);
        add(OP_R, 1'b1, FETCH_OK | 24'd0);
        add(OP_R, 1'b1, ASB11 | 24'd1);
        add(OP_R, 1'b1, ASA | AOP10 | 24'd6);
        add(OP_R, 1'b1, REGW | RDST | 24'd7);
        // ori
        add(OP_ORI, 1'b1, FETCH_OK | 24'd0);
        add(OP_ORI, 1'b1, ASB11 | 24'd1);
        add(OP_ORI, 1'b1, ASA | ASB10 | AOP11 | ZEXT | 24'd9);
        add(OP_ORI, 1'b1, REGW | ZEXT | 24'd10);
        // bne
        add(OP_BNE, 1'b1, FETCH_OK | 24'd0);
        add(OP_BNE, 1'b1, ASB11 | 24'd1);
        add(OP_BNE, 1'b1, ASA | AOP01 | PCS01 | BRNE | 24'd8);
        // beq
        add(OP_BEQ, 1'b1, FETCH_OK | 24'd0);
        add(OP_BEQ, 1'b1, ASB11 | 24'd1);
        add(OP_BEQ, 1'b1, ASA | AOP01 | PCS01 | BR | 24'd8);
        // addi
        add(OP_ADDI, 1'b1, FETCH_OK | 24'd0);
        add(OP_ADDI, 1'b1, ASB11 | 24'd1);
        add(OP_ADDI, 1'b1, ASA | ASB10 | 24'd9);
        add(OP_ADDI, 1'b1, REGW | 24'd10);
        // j
        add(OP_J, 1'b1, FETCH_OK | 24'd0);
        add(OP_J, 1'b1, ASB11 | 24'd1);
        add(OP_J, 1'b1, PCS10 | PCW | 24'd11);
        // illegal opcode, then andi
        add(OP_BAD, 1'b1, FETCH_OK | 24'd0);
        add(OP_BAD, 1'b1, ASB11 | ILL | 24'd1);
        add(OP_ANDI, 1'b1, FETCH_OK | 24'd0);
        add(OP_ANDI, 1'b1, ASB11 | 24'd1);
        add(OP_ANDI, 1'b1, ASA | ASB10 | AOP11 | ZEXT | 24'd9);
        add(OP_ANDI, 1'b1, REGW | ZEXT | 24'd10);
        add(OP_SW, 1'b1, FETCH_OK | 24'd0);

        // Reset state: nothing requested while rst_n is low
        @(negedge clk);
        rdy_v[0] = 1'b1;
        #1;
        chk("reset_outputs", obus[0], 24'h000000);
        @(negedge clk);
        rst_v[0] = 1'b1;

        foreach (tbl[i]) step(0, tbl[i].op, tbl[i].rdy, tbl[i].exp, $sformatf("tbl[%0d]", i));

        // Async reset in the middle of a stalled sw
        step(0, OP_SW, 1'b1, ASB11 | 24'd1, "sw_decode");
        step(0, OP_SW, 1'b0, ASA | ASB10 | 24'd2, "sw_memadr");
        step(0, OP_SW, 1'b0, MREQ | IORD | MEMW | 24'd5, "sw_memwr");
        rst_v[0] = 1'b0;
        rdy_v[0] = 1'b1;
        #1;
        chk("async_reset", obus[0], 24'h000000);
        @(negedge clk);
        chk("reset_held", obus[0], 24'h000000);
        rst_v[0] = 1'b1;
        step(0, OP_SW, 1'b0, FETCH_ST | 24'd0, "post_reset_fetch");
        step(0, OP_SW, 1'b0, FETCH_ST | 24'd0, "post_reset_hold");
        rst_v[0] = 1'b0;

        // EXT_EN=0, MEM_WAIT_EN=0 with mem_ready tied low
        rst_v[1] = 1'b1;
        step(1, OP_ANDI, 1'b0, FETCH_OK | 24'd0, "x_fetch_noready");
        step(1, OP_ANDI, 1'b0, ASB11 | ILL | 24'd1, "x_andi_illegal");
        step(1, OP_BNE, 1'b0, FETCH_OK | 24'd0, "x_fetch2");
        step(1, OP_BNE, 1'b0, ASB11 | ILL | 24'd1, "x_bne_illegal");
        step(1, OP_LW, 1'b0, FETCH_OK | 24'd0, "x_fetch3");
        step(1, OP_LW, 1'b0, ASB11 | 24'd1, "x_lw_decode");
        step(1, OP_LW, 1'b0, ASA | ASB10 | 24'd2, "x_lw_memadr");
        step(1, OP_LW, 1'b0, MREQ | IORD | 24'd3, "x_memrd_1cyc");
        step(1, OP_LW, 1'b0, REGW | M2R | 24'd4, "x_memwb");
        step(1, OP_LW, 1'b0, FETCH_OK | 24'd0, "x_fetch4");
        rst_v[1] = 1'b0;

        // TIMEOUT=8: ready on the expiry cycle wins
        rst_v[2] = 1'b1;
        for (int k = 0; k < 7; k++) step(2, OP_R, 1'b0, FETCH_ST | 24'd0, $sformatf("t_stall%0d", k));
        step(2, OP_R, 1'b1, FETCH_OK | 24'd0, "t_ready_on_expiry");
        step(2, OP_R, 1'b0, ASB11 | 24'd1, "t_no_timeout");
        step(2, OP_R, 1'b0, ASA | AOP10 | 24'd6, "t_exec");
        step(2, OP_R, 1'b0, REGW | RDST | 24'd7, "t_aluwb");
        // 8 stalled fetch cycles trip the watchdog
        for (int k = 0; k < 8; k++) step(2, OP_LW, 1'b0, FETCH_ST | 24'd0, $sformatf("t_wait%0d", k));
        step(2, OP_LW, 1'b0, FETCH_ST | TMO | 24'd0, "t_timeout_set");
        step(2, OP_LW, 1'b1, FETCH_OK | TMO | 24'd0, "t_sticky_fetch");
        step(2, OP_LW, 1'b0, ASB11 | TMO | 24'd1, "t_sticky_decode");
        step(2, OP_LW, 1'b0, ASA | ASB10 | TMO | 24'd2, "t_memadr");
        for (int k = 0; k < 8; k++) step(2, OP_LW, 1'b0, MREQ | IORD | TMO | 24'd3, $sformatf("t_memrd%0d", k));
        step(2, OP_LW, 1'b0, FETCH_ST | TMO | 24'd0, "t_memrd_abort");
        rst_v[2] = 1'b0;
        #1;
        chk("t_reset_clears", obus[2], 24'h000000);
        @(negedge clk);
        rst_v[2] = 1'b1;
        step(2, OP_LW, 1'b0, FETCH_ST | 24'd0, "t_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
